// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
//   Shared types and constants for the UART program loader.
//   - state_t    : loader FSM states
//   - rx_state_t : UART receiver states
//   - DATA_W     : width of a loaded memory word
//   - CNT_W      : width of the word count N and the word index i
// ---------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, LSB first, idle high. Expects an already
//   synchronized serial input.
//   Ports:
//     clk        : clock, rising edge
//     reset_n    : asynchronous active-low reset
//     rxd        : synchronized serial input
//     byte_out   : last received byte
//     byte_valid : one-cycle pulse, byte_out valid (stop bit sampled high)
//     frame_err  : one-cycle pulse, stop bit sampled low (no byte_valid)
// ---------------------------------------------------------------------------
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  // Start bit is rechecked half a bit after the falling edge.
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          prev_q, prev_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    prev_d  = rxd;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rxd) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          // A line that is high again at mid-start-bit was a glitch.
          state_d = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rxd, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rxd;
          ferr_d  = !rxd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_out   = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Receives a program over UART and writes it into data memory while
//   holding the cpu in reset. Stream after a start pulse:
//     N[7:0], N[15:8], then N little-endian 32-bit words.
//   Word i is written to BASE_ADDR + 4*i; after the last word the cpu is
//   released. A stop-bit framing error aborts the load into ERR.
//   Ports:
//     clk           : clock, rising edge
//     reset_n       : asynchronous active-low reset
//     start         : one-cycle pulse, (re)starts a load
//     uart_rxd      : UART serial input (asynchronous)
//     Ext_MemWrite  : one-cycle memory write strobe
//     Ext_WriteData : memory write data (holds last value)
//     Ext_DataAdr   : memory write byte address (holds last value)
//     cpu_reset     : hold cpu in reset (low only while running)
//     load_done     : program loaded and running
//     load_err      : framing error seen, cleared by next start
// ---------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 868,
  parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              uart_rxd,
  output logic              Ext_MemWrite,
  output logic [DATA_W-1:0] Ext_WriteData,
  output logic [DATA_W-1:0] Ext_DataAdr,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  // Two-flop synchronizer, idles high like the line.
  logic rxd_meta_q, rxd_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd_sync_q),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  i_inc;

  assign i_inc = i_q + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    if (start) begin
      // start beats any byte arriving in the same cycle.
      state_d = HDR0;
      i_d     = '0;
      bcnt_d  = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        HDR0: begin
          if (rx_ferr) begin
            state_d = ERR;
          end else if (rx_valid) begin
            n_d[7:0] = rx_byte;
            state_d  = HDR1;
          end
        end
        HDR1: begin
          if (rx_ferr) begin
            state_d = ERR;
          end else if (rx_valid) begin
            n_d[15:8] = rx_byte;
            state_d   = ({rx_byte, n_q[7:0]} == '0) ? RUN : DATA;
          end
        end
        DATA: begin
          if (rx_ferr) begin
            state_d = ERR;
            bcnt_d  = '0;
            word_d  = '0;
          end else if (rx_valid) begin
            if (bcnt_q == 2'd3) begin
              // Word complete: present it together with its address.
              wdata_d = {rx_byte, word_q[23:0]};
              addr_d  = BASE_ADDR + {{(DATA_W-CNT_W-2){1'b0}}, i_q, 2'b00};
              word_d  = '0;
              bcnt_d  = '0;
              state_d = WRITE;
            end else begin
              word_d[8*bcnt_q +: 8] = rx_byte;
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          i_d     = i_inc;
          state_d = (i_inc == n_q) ? RUN : DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Ext_MemWrite = (state_q == WRITE);
    cpu_reset    = (state_q != RUN);
    load_done    = (state_q == RUN);
    load_err     = (state_q == ERR);
  end

  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader with CLKS_PER_BIT=4. Full loads come
//   from a vector table; glitch, restart and reset cases are hand-written.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int CPB = 4;
  localparam int NV  = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .uart_rxd     (uart_rxd),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write-pulse recorder, plus the status seen the cycle after each pulse.
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  int          wr_cnt = 0;
  logic        pend = 1'b0;
  logic        after_rst = 1'b0;
  logic        after_done = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      after_rst  <= cpu_reset;
      after_done <= load_done;
    end
    pend <= Ext_MemWrite;
    if (Ext_MemWrite) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] <= Ext_DataAdr;
        wr_data[wr_cnt] <= Ext_WriteData;
      end
      wr_cnt <= wr_cnt + 1;
      $display("write pulse addr=%h data=%h", Ext_DataAdr, Ext_WriteData);
    end
  end

  typedef struct packed {
    int          nb;     // bytes to send
    logic [79:0] bs;     // bytes in send order, left-aligned
    logic        bad;    // last byte sent with a low stop bit
    int          nw;     // expected write pulses
    logic [1:0][31:0] a; // expected addresses
    logic [1:0][31:0] d; // expected data
    logic        done;   // expected load_done at end
    logic        err;    // expected load_err at end
  } vec_t;

  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      repeat (CPB) tick();
    end
    uart_rxd = stop_bit;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic rst, input logic done, input logic err);
    chk({tag, " cpu_reset"}, {31'b0, cpu_reset}, {31'b0, rst});
    chk({tag, " load_done"}, {31'b0, load_done}, {31'b0, done});
    chk({tag, " load_err"},  {31'b0, load_err},  {31'b0, err});
  endtask

  int base;

  initial begin
    vecs[0] = '{nb: 10, bs: 80'h0200_1305_A000_EFBE_ADDE, bad: 1'b0, nw: 2,
                a: {32'h0000_0004, 32'h0000_0000}, d: {32'hDEAD_BEEF, 32'h00A0_0513},
                done: 1'b1, err: 1'b0};
    vecs[1] = '{nb: 2, bs: {16'h0000, 64'h0}, bad: 1'b0, nw: 0,
                a: '0, d: '0, done: 1'b1, err: 1'b0};
    vecs[2] = '{nb: 5, bs: {40'h0100_1122_33, 40'h0}, bad: 1'b1, nw: 0,
                a: '0, d: '0, done: 1'b0, err: 1'b1};
    vecs[3] = '{nb: 6, bs: {48'h0100_AABB_CCDD, 32'h0}, bad: 1'b0, nw: 1,
                a: {32'h0, 32'h0000_0000}, d: {32'h0, 32'hDDCC_BBAA},
                done: 1'b1, err: 1'b0};
    vecs[4] = '{nb: 6, bs: {48'h0100_7856_3412, 32'h0}, bad: 1'b0, nw: 1,
                a: {32'h0, 32'h0000_0000}, d: {32'h0, 32'h1234_5678},
                done: 1'b1, err: 1'b0};

    // Reset values
    repeat (3) tick();
    chk("reset MemWrite",  {31'b0, Ext_MemWrite}, 32'h0);
    chk("reset WriteData", Ext_WriteData, 32'h0);
    chk("reset DataAdr",   Ext_DataAdr,   32'h0);
    chk_status("reset", 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Bytes and glitches with no start: nothing happens
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
    repeat (48) tick();
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (10) tick();
    chk("idle writes", wr_cnt, 0);
    chk_status("idle", 1'b1, 1'b0, 1'b0);

    // Table-driven loads, each starting from the previous end state
    for (int v = 0; v < NV; v++) begin
      base = wr_cnt;
      pulse_start();
      chk_status($sformatf("v%0d after start", v), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < vecs[v].nb; k++) begin
        send_byte(vecs[v].bs[79-8*k -: 8], !(vecs[v].bad && (k == vecs[v].nb - 1)));
        if (vecs[v].nb > 2 && k == vecs[v].nb - 2)
          chk($sformatf("v%0d mid cpu_reset", v), {31'b0, cpu_reset}, 32'h1);
      end
      repeat (2) tick();
      chk($sformatf("v%0d write count", v), wr_cnt - base, vecs[v].nw);
      for (int w = 0; w < vecs[v].nw; w++) begin
        chk($sformatf("v%0d w%0d addr", v, w), wr_addr[base+w], vecs[v].a[w]);
        chk($sformatf("v%0d w%0d data", v, w), wr_data[base+w], vecs[v].d[w]);
      end
      if (vecs[v].nw > 0) begin
        chk($sformatf("v%0d post-write load_done", v), {31'b0, after_done}, 32'h1);
        chk($sformatf("v%0d post-write cpu_reset", v), {31'b0, after_rst}, 32'h0);
      end
      chk($sformatf("v%0d MemWrite idle", v), {31'b0, Ext_MemWrite}, 32'h0);
      chk_status($sformatf("v%0d end", v), !vecs[v].done, vecs[v].done, vecs[v].err);
    end

    // Short glitch right after start must not be taken as a start bit
    base = wr_cnt;
    pulse_start();
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (10) tick();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (2) tick();
    chk("glitch write count", wr_cnt - base, 1);
    chk("glitch data", wr_data[base], 32'h1122_3344);
    chk_status("glitch end", 1'b0, 1'b1, 1'b0);

    // start mid-load discards progress
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    repeat (2) tick();
    chk("restart write count", wr_cnt - base, 1);
    chk("restart addr", wr_addr[base], 32'h0000_0000);
    chk("restart data", wr_data[base], 32'h8877_6655);
    chk_status("restart end", 1'b0, 1'b1, 1'b0);

    // Reset between 3rd and 4th data byte
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midreset MemWrite",  {31'b0, Ext_MemWrite}, 32'h0);
    chk("midreset WriteData", Ext_WriteData, 32'h0);
    chk("midreset DataAdr",   Ext_DataAdr,   32'h0);
    chk_status("midreset", 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    send_byte(8'hDD, 1'b1);
    repeat (2) tick();
    chk("midreset write count", wr_cnt - base, 0);
    chk_status("after midreset", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
